// File: rtl/load_store_unit.sv
// Load/store unit: turns a MemRead/MemWrite instruction into one bus transaction and formats the data.
// Latency: Stall is high for at least 3 cycles (accept, request, response); the result is shown in DONE.
// Backpressure: request fields are held while bus_ready is low; bus_rvalid is awaited; abort after TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [31:0] rdata_q;

    logic        f3_legal;
    logic        misaligned;
    logic        accept;
    logic        idle_err;
    logic        busy;
    logic        timeout_hit;
    logic [16:0] tmo_next;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // Decode the instruction presented in IDLE: legality, alignment, accept or fault.
    always_comb begin
        f3_legal = 1'b0;
        if (MemWrite) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b01:   misaligned = ALUResult[0];
            2'b10:   misaligned = (ALUResult[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        // Gated by reset so Stall/Fault fall asynchronously with it.
        accept   = reset && (state == IDLE) && (MemRead ^ MemWrite) && f3_legal && !misaligned;
        idle_err = reset && (state == IDLE) && (MemRead | MemWrite) && !accept;
    end

    // Replicate store data across the word and build the byte enables from the low address bits.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{WriteData[7:0]}};
                st_wstrb = 4'b0001 << ALUResult[1:0];
            end
            2'b01: begin
                st_wdata = {2{WriteData[15:0]}};
                st_wstrb = ALUResult[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = WriteData;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Select and extend the loaded byte/half using the latched size and offset.
    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = bus_rdata;
        endcase
    end

    // Timeout fires on the TIMEOUT_CYCLES-th cycle spent in REQ plus RESP.
    always_comb begin
        busy        = (state == REQ) || (state == RESP);
        tmo_next    = {1'b0, tmo_cnt} + 17'd1;
        timeout_hit = busy && (tmo_next == 17'(TIMEOUT_CYCLES));
    end

    // Outputs decoded from the state register; bus_valid is masked on an aborting cycle
    // so an abandoned request can never be accepted by the slave.
    always_comb begin
        bus_valid = (state == REQ) && !timeout_hit;
        Stall     = accept || (busy && !timeout_hit);
        Fault     = idle_err || timeout_hit;
        ReadData  = (state == DONE) ? rdata_q : 32'd0;
    end

    // Transaction FSM: latch request in IDLE, handshake in REQ, capture response in RESP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tmo_cnt    <= 16'd0;
            lat_funct3 <= 3'd0;
            lat_off    <= 2'd0;
            rdata_q    <= 32'd0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_wstrb  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_addr   <= {ALUResult[31:2], 2'b00};
                        bus_we     <= MemWrite;
                        bus_wdata  <= MemWrite ? st_wdata : 32'd0;
                        bus_wstrb  <= MemWrite ? st_wstrb : 4'd0;
                        lat_funct3 <= funct3;
                        lat_off    <= ALUResult[1:0];
                        tmo_cnt    <= 16'd0;
                        rdata_q    <= 32'd0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_next[15:0];
                        if (bus_ready) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_next[15:0];
                        if (bus_rvalid) begin
                            rdata_q <= bus_we ? 32'd0 : ld_fmt;
                            state   <= DONE;
                        end
                    end
                end
                default: begin
                    // DONE lasts one cycle so the same instruction is never reissued.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized transactions against a behavioural model.
// A second instance with a short timeout exercises the abort path.
// The bus slave responds with configurable ready/rvalid delays.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic [31:0] ReadData, bus_addr, bus_wdata;
    logic        Stall, Fault, bus_valid, bus_we;
    logic [3:0]  bus_wstrb;

    logic [31:0] t4_ReadData, t4_bus_addr, t4_bus_wdata;
    logic        t4_Stall, t4_Fault, t4_bus_valid, t4_bus_we;
    logic [3:0]  t4_bus_wstrb;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent do_txn call.
    int          o_stall;
    int          o_fault;
    bit          o_valid;
    bit          o_stable;
    bit          o_done;
    bit          o_end_fault;
    logic        o_we;
    logic [31:0] o_rd, o_addr, o_wdata;
    logic [3:0]  o_wstrb;

    load_store_unit dut (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(t4_ReadData), .Stall(t4_Stall), .Fault(t4_Fault),
        .bus_valid(t4_bus_valid), .bus_ready(bus_ready), .bus_we(t4_bus_we),
        .bus_addr(t4_bus_addr), .bus_wdata(t4_bus_wdata), .bus_wstrb(t4_bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (rd && wr) return 1'b1;
        if (!rd && !wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 % 4 == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 % 4 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] s;
        if (f3 % 4 == 0) s = 32'd1 << (a % 4);
        else if (f3 % 4 == 1) s = ((a / 2) % 2 == 1) ? 32'hC : 32'h3;
        else s = 32'hF;
        return s[3:0];
    endfunction

    // ---------------- stimulus driver (records, does not judge) ----------------
    // Starts just after a rising edge with the DUT idle; returns after the cycle where Stall is low.
    task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int dr, input int dv,
                          input bit scramble);
        int  vcnt = 0;
        int  rcnt = 0;
        bit  waiting = 0;
        bit  hs, rv;
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd;
        bus_ready = 0; bus_rvalid = 0;
        o_stall = 0; o_fault = 0; o_valid = 0; o_stable = 1; o_done = 0; o_end_fault = 0;
        o_rd = 'x; o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_we = 'x;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            bus_ready  = bus_valid && (vcnt == dr);
            bus_rvalid = waiting && (rcnt == dv);
            bus_rdata  = bus_rvalid ? rw : $urandom;
            #1;
            if (Stall) o_stall++;
            if (Fault) o_fault++;
            if (bus_valid) begin
                if (!o_valid) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_we = bus_we;
                end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                             bus_wstrb !== o_wstrb || bus_we !== o_we) begin
                    o_stable = 0;
                end
                o_valid = 1;
            end
            if (!Stall) begin
                o_rd = ReadData; o_end_fault = Fault; o_done = 1;
            end
            hs = bus_valid && bus_ready;
            rv = bus_rvalid;
            if (bus_valid) vcnt++;
            if (waiting) rcnt++;
            @(posedge clock); #1;
            if (hs) waiting = 1;
            if (rv) waiting = 0;
            bus_ready = 0; bus_rvalid = 0;
            if (o_done) break;
            if (scramble) begin
                ALUResult = $urandom; WriteData = $urandom;
            end
        end
        MemRead = 0; MemWrite = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 0; MemRead = 0; MemWrite = 0; funct3 = 0; ALUResult = 0; WriteData = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        #3;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall); end
        checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", Fault); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_valid); end
        checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", ReadData); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus_we); end
        checks++; if (bus_wstrb !== 4'd0) begin errors++; $display("FAIL reset_wstrb got %h want 0", bus_wstrb); end
        MemRead = 1; funct3 = 3'b010;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall_with_req got %b want 0", Stall); end
        MemRead = 0;
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_load_byte;
        do_txn(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 1);
        checks++; if (o_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr got %h want 00001000", o_addr); end
        checks++; if (o_stall !== 3) begin errors++; $display("FAIL lb_stall got %0d want 3", o_stall); end
        checks++; if (o_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", o_rd); end
        checks++; if (o_fault !== 0) begin errors++; $display("FAIL lb_fault got %0d want 0", o_fault); end
        checks++; if (o_we !== 1'b0 || o_wstrb !== 4'd0) begin errors++; $display("FAIL lb_we_wstrb got %b/%h want 0/0", o_we, o_wstrb); end
        do_txn(1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 1);
        checks++; if (o_rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", o_rd); end
        checks++; if (o_stall !== 3) begin errors++; $display("FAIL lbu_stall got %0d want 3", o_stall); end
    endtask

    task automatic test_store_half;
        do_txn(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 2, 0, 1);
        checks++; if (o_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); end
        checks++; if (o_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b want 1100", o_wstrb); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", o_we); end
        checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b want 1", o_stable); end
        checks++; if (o_stall !== 5) begin errors++; $display("FAIL sh_stall got %0d want 5", o_stall); end
        checks++; if (o_rd !== 32'd0) begin errors++; $display("FAIL sh_readdata got %h want 0", o_rd); end
    endtask

    task automatic test_faults;
        bit          rds [5] = '{1, 1, 0, 1, 0};
        bit          wrs [5] = '{0, 1, 1, 0, 1};
        logic [2:0]  f3s [5] = '{3'b010, 3'b010, 3'b011, 3'b110, 3'b001};
        logic [31:0] as  [5] = '{32'h3001, 32'h3000, 32'h3000, 32'h3000, 32'h2001};
        for (int i = 0; i < 5; i++) begin
            do_txn(rds[i], wrs[i], f3s[i], as[i], 32'h5555_AAAA, 32'h1111_2222, 0, 0, 0);
            checks++; if (o_fault !== 1 || o_stall !== 0 || o_valid !== 1'b0 || o_rd !== 32'd0)
                begin errors++; $display("FAIL fault_case%0d got fault=%0d stall=%0d valid=%b rd=%h want 1 0 0 0", i, o_fault, o_stall, o_valid, o_rd); end
        end
    endtask

    task automatic test_random;
        int          k, dr, dv, ef, estall;
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, rw, erd;
        logic [2:0]  rlegal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 9);
            rd = (k == 1) || (k >= 2 && k <= 5);
            wr = (k == 1) || (k >= 6);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr && !rd) f3 = 3'($urandom_range(0, 2));
            else f3 = rlegal[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = (f3 % 4 == 1) ? (a & ~32'd1) : (f3 % 4 == 2) ? (a & ~32'd3) : a;
            wd = $urandom; rw = $urandom;
            dr = $urandom_range(0, 4); dv = $urandom_range(0, 4);
            do_txn(rd, wr, f3, a, wd, rw, dr, dv, 1);
            ef = model_fault(rd, wr, f3, a) ? 1 : 0;
            if (!rd && !wr) begin
                checks++; if (o_stall !== 0 || o_fault !== 0 || o_valid !== 1'b0)
                    begin errors++; $display("FAIL rnd%0d_none got stall=%0d fault=%0d valid=%b want 0 0 0", n, o_stall, o_fault, o_valid); end
            end else if (ef == 1) begin
                checks++; if (o_stall !== 0 || o_fault !== 1 || o_valid !== 1'b0 || o_rd !== 32'd0)
                    begin errors++; $display("FAIL rnd%0d_err got stall=%0d fault=%0d valid=%b rd=%h want 0 1 0 0", n, o_stall, o_fault, o_valid, o_rd); end
            end else begin
                estall = dr + dv + 3;
                erd    = wr ? 32'd0 : model_load(f3, a, rw);
                checks++; if (o_stall !== estall || o_fault !== 0 || o_rd !== erd)
                    begin errors++; $display("FAIL rnd%0d_result got stall=%0d fault=%0d rd=%h want %0d 0 %h", n, o_stall, o_fault, o_rd, estall, erd); end
                checks++; if (o_addr !== (a & ~32'd3) || o_we !== logic'(wr) || o_stable !== 1'b1)
                    begin errors++; $display("FAIL rnd%0d_req got addr=%h we=%b stable=%b want %h %b 1", n, o_addr, o_we, o_stable, a & ~32'd3, wr); end
                if (wr) begin
                    checks++; if (o_wdata !== model_wdata(f3, wd) || o_wstrb !== model_wstrb(f3, a))
                        begin errors++; $display("FAIL rnd%0d_store got wdata=%h wstrb=%h want %h %h", n, o_wdata, o_wstrb, model_wdata(f3, wd), model_wstrb(f3, a)); end
                end else begin
                    checks++; if (o_wstrb !== 4'd0)
                        begin errors++; $display("FAIL rnd%0d_load_wstrb got %h want 0", n, o_wstrb); end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        reset = 0; #2; reset = 1;
        // Reset while in REQ.
        MemRead = 1; MemWrite = 0; funct3 = 3'b010; ALUResult = 32'h4000; bus_ready = 0; bus_rvalid = 0;
        @(posedge clock); #1;
        @(negedge clock); #1;
        checks++; if (bus_valid !== 1'b1 || Stall !== 1'b1) begin errors++; $display("FAIL mid_req_active got valid=%b stall=%b want 1 1", bus_valid, Stall); end
        reset = 0; #1;
        checks++; if (bus_valid !== 1'b0 || Stall !== 1'b0 || Fault !== 1'b0) begin errors++; $display("FAIL mid_req_reset got valid=%b stall=%b fault=%b want 0 0 0", bus_valid, Stall, Fault); end
        MemRead = 0;
        @(posedge clock); #1; reset = 1;
        // Reset while in RESP of a store.
        MemWrite = 1; funct3 = 3'b010; ALUResult = 32'h4000; WriteData = 32'hCAFE_F00D;
        @(posedge clock); #1;
        bus_ready = 1;
        @(posedge clock); #1;
        bus_ready = 0;
        @(negedge clock); #1;
        checks++; if (Stall !== 1'b1 || bus_valid !== 1'b0 || bus_we !== 1'b1) begin errors++; $display("FAIL mid_resp_active got stall=%b valid=%b we=%b want 1 0 1", Stall, bus_valid, bus_we); end
        reset = 0; #1;
        checks++; if (Stall !== 1'b0 || ReadData !== 32'd0 || bus_we !== 1'b0 || bus_wstrb !== 4'd0 || Fault !== 1'b0)
            begin errors++; $display("FAIL mid_resp_reset got stall=%b rd=%h we=%b wstrb=%h fault=%b want 0 0 0 0 0", Stall, ReadData, bus_we, bus_wstrb, Fault); end
        MemWrite = 0;
        @(posedge clock); #1; reset = 1;
        // Stray responses in IDLE must be ignored.
        for (int i = 0; i < 2; i++) begin
            bus_rvalid = 1; bus_rdata = $urandom;
            @(negedge clock); #1;
            checks++; if (Stall !== 1'b0 || bus_valid !== 1'b0 || ReadData !== 32'd0 || Fault !== 1'b0)
                begin errors++; $display("FAIL stray_rvalid%0d got stall=%b valid=%b rd=%h fault=%b want 0 0 0 0", i, Stall, bus_valid, ReadData, Fault); end
            @(posedge clock); #1;
        end
        bus_rvalid = 0;
        do_txn(1, 0, 3'b010, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        checks++; if (o_rd !== 32'hDEAD_BEEF || o_stall !== 3) begin errors++; $display("FAIL after_reset_lw got rd=%h stall=%0d want deadbeef 3", o_rd, o_stall); end
    endtask

    task automatic test_timeout;
        int          fault_at, stall_cnt, valid_cnt;
        logic        stall_at_fault;
        logic [31:0] rd_at_fault;
        for (int mode = 0; mode < 2; mode++) begin
            reset = 0; MemRead = 0; MemWrite = 0; bus_ready = 0; bus_rvalid = 0;
            #2; reset = 1;
            MemRead = 1; funct3 = 3'b010; ALUResult = 32'h5000;
            fault_at = -1; stall_cnt = 0; valid_cnt = 0; stall_at_fault = 1'bx; rd_at_fault = 'x;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clock);
                bus_ready = (mode == 1) && t4_bus_valid;
                #1;
                if (t4_Fault) begin
                    fault_at = cyc; stall_at_fault = t4_Stall; rd_at_fault = t4_ReadData;
                end else begin
                    if (t4_Stall) stall_cnt++;
                    if (t4_bus_valid) valid_cnt++;
                end
                @(posedge clock); #1;
                bus_ready = 0;
                if (fault_at >= 0) break;
            end
            MemRead = 0;
            checks++; if (fault_at !== 4) begin errors++; $display("FAIL tmo%0d_fault_cycle got %0d want 4", mode, fault_at); end
            checks++; if (stall_cnt !== 4 || stall_at_fault !== 1'b0 || rd_at_fault !== 32'd0)
                begin errors++; $display("FAIL tmo%0d_abort got stall_cycles=%0d stall=%b rd=%h want 4 0 0", mode, stall_cnt, stall_at_fault, rd_at_fault); end
            checks++; if (valid_cnt !== ((mode == 0) ? 3 : 1))
                begin errors++; $display("FAIL tmo%0d_valid_cycles got %0d want %0d", mode, valid_cnt, (mode == 0) ? 3 : 1); end
            for (int i = 0; i < 2; i++) begin
                bus_rvalid = 1; bus_rdata = $urandom;
                @(negedge clock); #1;
                checks++; if (t4_Stall !== 1'b0 || t4_Fault !== 1'b0 || t4_bus_valid !== 1'b0 || t4_ReadData !== 32'd0)
                    begin errors++; $display("FAIL tmo%0d_late_rvalid%0d got stall=%b fault=%b valid=%b rd=%h want 0 0 0 0", mode, i, t4_Stall, t4_Fault, t4_bus_valid, t4_ReadData); end
                @(posedge clock); #1;
            end
            bus_rvalid = 0;
            MemRead = 1;
            #1;
            checks++; if (t4_Stall !== 1'b1) begin errors++; $display("FAIL tmo%0d_idle_accept got stall=%b want 1", mode, t4_Stall); end
            MemRead = 0;
        end
        reset = 0; #2; reset = 1;
    endtask

    initial begin
        test_reset;
        test_load_byte;
        test_store_half;
        test_faults;
        test_random;
        test_reset_mid;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
